cfg_chain_loader: RTL and testbench



---
 rtl/cfg_loader_pkg.sv | 18 +
 rtl/cfg_word_serializer.sv | 65 ++++++
 rtl/cfg_chain_loader.sv | 165 ++++++++++++++++
 tb/tb_cfg_chain_loader.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_loader_pkg.sv
// Shared constants for the configuration chain loader: FSM encoding,
// default header/timeout sizes and a counter-width helper.
package cfg_loader_pkg;

  localparam int unsigned ID_WIDTH_DEF = 3;
  localparam int unsigned TIMEOUT_DEF  = 1024;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HDR   = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_WAIT  = 2'd3;

  // Width of a down/up counter that must hold values 0..n-1 (never below 1).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cfg_word_serializer.sv
// One-word input buffer in front of a shift register; hands out payload
// bits LSB-first on demand with a zero-bubble reload from the buffer.
module cfg_word_serializer
  import cfg_loader_pkg::*;
#(
  parameter int unsigned WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              flush,
  input  logic              take,
  input  logic              drop,
  input  logic              word_valid,
  output logic              word_ready,
  input  logic [WORD_W-1:0] word_data,
  output logic              avail_c,
  output logic              bit_c
);

  localparam int unsigned CNT_W = $clog2(WORD_W + 1);

  logic [WORD_W-1:0] wbuf;
  logic [WORD_W-1:0] sr;
  logic              wbuf_full;
  logic [CNT_W-1:0]  sr_cnt;
  logic              sr_empty;

  assign sr_empty   = (sr_cnt == '0);
  assign word_ready = enable & ~wbuf_full;
  assign avail_c    = ~sr_empty | wbuf_full;
  // With the shift register drained the next bit comes straight from the buffer.
  assign bit_c      = sr_empty ? wbuf[0] : sr[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbuf      <= '0;
      sr        <= '0;
      wbuf_full <= 1'b0;
      sr_cnt    <= '0;
    end else if (flush) begin
      wbuf_full <= 1'b0;
      sr_cnt    <= '0;
    end else begin
      if (take) begin
        if (!sr_empty) begin
          sr     <= sr >> 1;
          sr_cnt <= sr_cnt - CNT_W'(1);
        end else begin
          sr        <= wbuf >> 1;
          sr_cnt    <= CNT_W'(WORD_W - 1);
          wbuf_full <= 1'b0;
        end
      end else if (drop) begin
        sr_cnt <= '0;
      end
      // Accept only into an empty buffer, so this never collides with a buffer pop.
      if (word_valid && word_ready) begin
        wbuf      <= word_data;
        wbuf_full <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cfg_chain_loader.sv
// Serial configuration-chain loader: sends a tile-ID header and an
// LSB-first payload, then waits for the frame-start echo or times out.
module cfg_chain_loader
  import cfg_loader_pkg::*;
#(
  parameter int unsigned WORD_W   = 32,
  parameter int unsigned ID_WIDTH = ID_WIDTH_DEF,
  parameter int unsigned LEN_W    = 16,
  parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                crst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ID_WIDTH-1:0] cmd_id,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic                word_valid,
  output logic                word_ready,
  input  logic [WORD_W-1:0]   word_data,
  output logic                cfg_in_start,
  output logic                cfg_bit_in,
  input  logic                cfg_out_start,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [LEN_W-1:0]    bits_sent
);

  localparam int unsigned HDR_W = cnt_w(ID_WIDTH);
  localparam int unsigned TMO_W = cnt_w(TIMEOUT);

  logic [1:0]          state, state_n;
  logic [ID_WIDTH-1:0] id_sr, id_sr_n;
  logic [HDR_W-1:0]    hdr_cnt, hdr_cnt_n;
  logic [LEN_W-1:0]    len_q, len_n;
  logic [LEN_W-1:0]    bits_n;
  logic [TMO_W-1:0]    wait_cnt, wait_n;
  logic                start_n, bit_n, done_n, err_n;
  logic                take, drop, need_bit;
  logic                ser_avail, ser_bit;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = ~cmd_ready;

  cfg_word_serializer #(
    .WORD_W (WORD_W)
  ) u_ser (
    .clk        (clk),
    .rst        (crst),
    .enable     (busy),
    .flush      (cmd_ready),
    .take       (take),
    .drop       (drop),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_data  (word_data),
    .avail_c    (ser_avail),
    .bit_c      (ser_bit)
  );

  // Next-state logic; registers hold what is driven in the current cycle.
  always_comb begin
    state_n   = state;
    id_sr_n   = id_sr;
    hdr_cnt_n = hdr_cnt;
    len_n     = len_q;
    bits_n    = bits_sent;
    wait_n    = wait_cnt;
    start_n   = 1'b0;
    bit_n     = 1'b0;
    done_n    = 1'b0;
    err_n     = 1'b0;
    take      = 1'b0;
    drop      = 1'b0;
    need_bit  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_n   = ST_HDR;
          id_sr_n   = cmd_id >> 1;
          hdr_cnt_n = HDR_W'(ID_WIDTH - 1);
          len_n     = cmd_len;
          bits_n    = '0;
          start_n   = 1'b1;
          bit_n     = cmd_id[0];
        end
      end
      ST_HDR: begin
        if (hdr_cnt != '0) begin
          hdr_cnt_n = hdr_cnt - HDR_W'(1);
          bit_n     = id_sr[0];
          id_sr_n   = id_sr >> 1;
        end else if (len_q != '0) begin
          need_bit = 1'b1;
        end else begin
          state_n = ST_WAIT;
          wait_n  = '0;
        end
      end
      ST_SHIFT: begin
        if (bits_sent != len_q) begin
          need_bit = 1'b1;
        end else begin
          state_n = ST_WAIT;
          wait_n  = '0;
          drop    = 1'b1;
        end
      end
      ST_WAIT: begin
        // Echo is checked first so it wins over a coinciding timeout.
        if (cfg_out_start) begin
          done_n  = 1'b1;
          state_n = ST_IDLE;
        end else if (wait_cnt == TMO_W'(TIMEOUT - 1)) begin
          err_n   = 1'b1;
          state_n = ST_IDLE;
        end else begin
          wait_n = wait_cnt + TMO_W'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // Payload bit slot: emit the next bit or abort on underrun.
    if (need_bit) begin
      if (ser_avail) begin
        state_n = ST_SHIFT;
        take    = 1'b1;
        bit_n   = ser_bit;
        bits_n  = bits_sent + LEN_W'(1);
      end else begin
        err_n   = 1'b1;
        state_n = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge crst) begin
    if (crst) begin
      state        <= ST_IDLE;
      id_sr        <= '0;
      hdr_cnt      <= '0;
      len_q        <= '0;
      bits_sent    <= '0;
      wait_cnt     <= '0;
      cfg_in_start <= 1'b0;
      cfg_bit_in   <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state        <= state_n;
      id_sr        <= id_sr_n;
      hdr_cnt      <= hdr_cnt_n;
      len_q        <= len_n;
      bits_sent    <= bits_n;
      wait_cnt     <= wait_n;
      cfg_in_start <= start_n;
      cfg_bit_in   <= bit_n;
      done         <= done_n;
      err          <= err_n;
    end
  end

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Self-checking bench for cfg_chain_loader: directed vector table, reset
// abort sequence and randomized frames against a frame-level model.
module tb_cfg_chain_loader;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned ID_WIDTH = 3;
  localparam int unsigned LEN_W    = 16;
  localparam int unsigned TIMEOUT  = 16;
  localparam int          IDW      = 3;
  localparam int          TMO      = 16;

  logic                clk = 1'b0;
  logic                crst;
  logic                cmd_valid;
  logic                cmd_ready;
  logic [ID_WIDTH-1:0] cmd_id;
  logic [LEN_W-1:0]    cmd_len;
  logic                word_valid;
  logic                word_ready;
  logic [WORD_W-1:0]   word_data;
  logic                cfg_in_start;
  logic                cfg_bit_in;
  logic                cfg_out_start;
  logic                busy;
  logic                done;
  logic                err;
  logic [LEN_W-1:0]    bits_sent;

  always #5 clk = ~clk;

  cfg_chain_loader #(
    .WORD_W   (WORD_W),
    .ID_WIDTH (ID_WIDTH),
    .LEN_W    (LEN_W),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk           (clk),
    .crst          (crst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_id        (cmd_id),
    .cmd_len       (cmd_len),
    .word_valid    (word_valid),
    .word_ready    (word_ready),
    .word_data     (word_data),
    .cfg_in_start  (cfg_in_start),
    .cfg_bit_in    (cfg_bit_in),
    .cfg_out_start (cfg_out_start),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .bits_sent     (bits_sent)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s (cycle t+%0d): got %0h expected %0h", name, k, act, exp);
    end
  endtask

  // Frame-level reference model state
  int          f_id, f_len, f_nw, f_d;
  logic [31:0] f_words[4];
  int          emitted, end_k, wait_k, echo_k;
  bit          done_case;
  logic [31:0] wq[$];

  function automatic void setup_model();
    int cap;
    cap    = f_nw * 32;
    wait_k = IDW + 1 + f_len;
    echo_k = -1;
    if (f_len > cap) begin
      emitted   = cap;
      end_k     = IDW + 1 + cap;
      done_case = 1'b0;
    end else begin
      emitted = f_len;
      if (f_d < TMO) begin
        echo_k    = wait_k + f_d;
        end_k     = wait_k + f_d + 1;
        done_case = 1'b1;
      end else begin
        end_k     = wait_k + TMO;
        done_case = 1'b0;
      end
    end
  endfunction

  function automatic logic exp_bit(input int k);
    int j;
    logic [31:0] w;
    if (k >= 1 && k <= IDW) return f_id[k-1];
    j = k - 1 - IDW;
    if (j >= 0 && j < emitted) begin
      w = f_words[j/32];
      return w[j%32];
    end
    return 1'b0;
  endfunction

  function automatic int exp_bits(input int k);
    if (k <= IDW) return 0;
    return (k - IDW < emitted) ? k - IDW : emitted;
  endfunction

  task automatic run_frame(input int id, input int len, input int nw,
                           input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3,
                           input int d, input int x_end, input int x_bits,
                           input int x_hs, input bit x_done, input int abort_k);
    int hs, seen_k;
    bit seen_done, pend, exp_busy;
    f_id = id; f_len = len; f_nw = nw; f_d = d;
    f_words[0] = w0; f_words[1] = w1; f_words[2] = w2; f_words[3] = w3;
    setup_model();
    wq.delete();
    for (int i = 0; i < nw; i++) wq.push_back(f_words[i]);
    check("cmd_ready_idle", 0, cmd_ready, 1);
    cmd_valid     = 1'b1;
    cmd_id        = ID_WIDTH'(id);
    cmd_len       = LEN_W'(len);
    word_valid    = (wq.size() > 0);
    word_data     = (wq.size() > 0) ? wq[0] : '0;
    cfg_out_start = 1'b0;
    hs = 0; seen_k = -1; seen_done = 1'b0; pend = 1'b0;
    for (int k = 1; k <= end_k + 1; k++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      if (pend) void'(wq.pop_front());
      exp_busy = (k < end_k);
      check("cfg_in_start", k, cfg_in_start, (k == 1));
      check("cfg_bit_in", k, cfg_bit_in, exp_bit(k));
      check("busy", k, busy, exp_busy);
      check("cmd_ready", k, cmd_ready, !exp_busy);
      check("done", k, done, (k == end_k) && done_case);
      check("err", k, err, (k == end_k) && !done_case);
      check("bits_sent", k, bits_sent, exp_bits(k));
      if (nw == 0 || !exp_busy) check("word_ready", k, word_ready, exp_busy);
      if (seen_k < 0 && (done || err)) begin
        seen_k = k;
        seen_done = done;
      end
      if (k == abort_k) begin
        #1 crst = 1'b1;
        #1;
        check("rst_start", k, cfg_in_start, 0);
        check("rst_bit", k, cfg_bit_in, 0);
        check("rst_busy", k, busy, 0);
        check("rst_bits_sent", k, bits_sent, 0);
        check("rst_word_ready", k, word_ready, 0);
        check("rst_cmd_ready", k, cmd_ready, 1);
        word_valid = 1'b0; cfg_out_start = 1'b0; wq.delete();
        for (int r = 1; r <= 2; r++) begin
          @(posedge clk); #1;
          check("rst_done", k + r, done, 0);
          check("rst_err", k + r, err, 0);
        end
        crst = 1'b0;
        for (int r = 3; r <= 5; r++) begin
          @(posedge clk); #1;
          check("post_rst_quiet", k + r, {done, err, cfg_in_start, busy}, 0);
        end
        #1;
        return;
      end
      word_valid    = (wq.size() > 0);
      word_data     = (wq.size() > 0) ? wq[0] : '0;
      cfg_out_start = (k == echo_k) || (k < wait_k && $urandom_range(0, 3) == 0);
      #1;
      pend = word_valid && word_ready;
      if (pend) hs++;
    end
    check("end_cycle", 0, seen_k, x_end);
    check("end_kind_done", 0, seen_done, x_done);
    check("bits_final", 0, bits_sent, x_bits);
    if (x_hs >= 0) check("word_handshakes", 0, hs, x_hs);
    word_valid = 1'b0; cfg_out_start = 1'b0; wq.delete();
  endtask

  typedef struct {
    int          id;
    int          len;
    int          nw;
    logic [31:0] w0;
    logic [31:0] w1;
    int          d;
    int          x_end;
    int          x_bits;
    int          x_hs;
    bit          x_done;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{5,  8, 1, 32'h000000A5, 32'h0,        0, 13,  8, 1, 1'b1};
    tbl[1] = '{3, 40, 2, 32'h12345678, 32'hFFFFFFFF, 5, 50, 40, 2, 1'b1};
    tbl[2] = '{1, 64, 1, 32'hCAFEF00D, 32'h0,        0, 36, 32, 1, 1'b0};
    tbl[3] = '{6,  4, 1, 32'h0000000F, 32'h0,       99, 24,  4, 1, 1'b0};
    tbl[4] = '{2,  0, 0, 32'h0,        32'h0,        2,  7,  0, 0, 1'b1};
    tbl[5] = '{7, 32, 1, 32'hDEADBEEF, 32'h0,       15, 52, 32, 1, 1'b1};
    tbl[6] = '{0,  1, 0, 32'h0,        32'h0,        0,  4,  0, 0, 1'b0};

    crst = 1'b1; cmd_valid = 1'b0; cmd_id = '0; cmd_len = '0;
    word_valid = 1'b0; word_data = '0; cfg_out_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 0, {cfg_in_start, cfg_bit_in, done, err, busy, word_ready}, 0);
    check("reset_bits_sent", 0, bits_sent, 0);
    check("reset_cmd_ready", 0, cmd_ready, 1);
    crst = 1'b0;
    @(posedge clk); #2;

    for (int i = 0; i < 7; i++)
      run_frame(tbl[i].id, tbl[i].len, tbl[i].nw, tbl[i].w0, tbl[i].w1, 32'h0, 32'h0,
                tbl[i].d, tbl[i].x_end, tbl[i].x_bits, tbl[i].x_hs, tbl[i].x_done, -1);

    // Reset while payload bit 10 is on the chain, then a clean restart
    run_frame(5, 40, 2, 32'h0F0F3C3C, 32'hA5A5A5A5, 32'h0, 32'h0, 0, 0, 0, -1, 1'b0, IDW + 1 + 10);
    run_frame(tbl[0].id, tbl[0].len, tbl[0].nw, tbl[0].w0, tbl[0].w1, 32'h0, 32'h0,
              tbl[0].d, tbl[0].x_end, tbl[0].x_bits, tbl[0].x_hs, tbl[0].x_done, -1);

    for (int n = 0; n < 30; n++) begin
      int id, len, nw, d;
      logic [31:0] r0, r1, r2, r3;
      id  = int'($urandom_range(0, 7));
      len = int'($urandom_range(0, 100));
      nw  = int'($urandom_range(0, 3));
      d   = int'($urandom_range(0, TMO + 2));
      r0 = $urandom; r1 = $urandom; r2 = $urandom; r3 = $urandom;
      f_nw = nw; f_len = len; f_d = d;
      setup_model();
      run_frame(id, len, nw, r0, r1, r2, r3, d, end_k, emitted, -1, done_case, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
